// File: rtl/iob_native_bus_split.sv
// Native CPU bus to 1+N_DCH IOb channel splitter: channel 0 takes instruction fetches, data
// accesses decode on address MSBs. One registered transaction in flight, with error responses.
module iob_native_bus_split #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned N_DCH       = 2,
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          rst_i,
  input  logic                          cpu_valid_i,
  input  logic                          cpu_instr_i,
  input  logic [ADDR_W-1:0]             cpu_addr_i,
  input  logic [DATA_W-1:0]             cpu_wdata_i,
  input  logic [DATA_W/8-1:0]           cpu_wstrb_i,
  output logic [DATA_W-1:0]             cpu_rdata_o,
  output logic                          cpu_ready_o,
  output logic [N_DCH:0]                iob_valid_o,
  output logic [ADDR_W-1:0]             iob_addr_o,
  output logic [DATA_W-1:0]             iob_wdata_o,
  output logic [DATA_W/8-1:0]           iob_wstrb_o,
  input  logic [N_DCH:0]                iob_ready_i,
  input  logic [N_DCH:0]                iob_rvalid_i,
  input  logic [(1+N_DCH)*DATA_W-1:0]   iob_rdata_i,
  output logic                          err_o
);

  localparam int unsigned NCH    = 1 + N_DCH;
  localparam int unsigned SEL_W  = (N_DCH > 1) ? $clog2(N_DCH) : 1;
  localparam int unsigned CH_W   = $clog2(NCH);
  localparam int unsigned TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    sel;
  logic                dec_err;
  logic [CH_W-1:0]     dec_ch;
  logic                accept;
  logic                timeout_hit;
  logic                ch_ready;
  logic                ch_rvalid;
  logic [DATA_W-1:0]   ch_rdata;

  assign sel     = cpu_addr_i[ADDR_W-1 -: SEL_W];
  assign dec_err = !cpu_instr_i && (32'(sel) >= N_DCH);
  assign dec_ch  = cpu_instr_i ? '0 : CH_W'(sel) + CH_W'(1);
  assign accept  = cpu_valid_i && !cpu_ready_o;

  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TmrLast);
  assign ch_ready    = iob_ready_i[ch_q];
  assign ch_rvalid   = iob_rvalid_i[ch_q];

  always_comb begin
    ch_rdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) ch_rdata = iob_rdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) state_q <= StIdle;
      else       state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = dec_err ? StResp : StReq;
      StReq: begin
        if (ch_ready)         state_d = (wstrb_q != '0) ? StResp : StWaitR;
        else if (timeout_hit) state_d = StResp;
      end
      StWaitR: if (ch_rvalid || timeout_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    iob_valid_o = '0;
    if (state_q == StReq) iob_valid_o[ch_q] = 1'b1;
    cpu_ready_o = (state_q == StResp);
    cpu_rdata_o = rdata_q;
    iob_addr_o  = addr_q;
    iob_wdata_o = wdata_q;
    iob_wstrb_o = wstrb_q;
    err_o       = err_q;
  end

  always_comb begin
    ch_d    = ch_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ch_d    = dec_ch;
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          timer_d = '0;
          if (dec_err) begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
          end
        end
      end
      StReq: begin
        timer_d = timer_q + TMR_W'(1);
        if (!ch_ready && timeout_hit) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
        end
      end
      StWaitR: begin
        timer_d = timer_q + TMR_W'(1);
        if (ch_rvalid) begin
          rdata_d = ch_rdata;
        end else if (timeout_hit) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        ch_q    <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        wstrb_q <= '0;
        rdata_q <= '0;
        timer_q <= '0;
        err_q   <= 1'b0;
      end else begin
        ch_q    <= ch_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        rdata_q <= rdata_d;
        timer_q <= timer_d;
        err_q   <= err_d;
      end
    end
  end

endmodule
